// File: rtl/m_receiver_pkg.sv
// Shared receiver definitions: FSM states, status bit positions and status packing.
// Also used by m_transmitter status decoding so both sides agree on bit meanings.
package m_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int ST_BUSY       = 0;
  localparam int ST_FRAME_ERR  = 1;
  localparam int ST_OVERFLOW   = 2;
  localparam int ST_EMPTY      = 3;
  localparam int ST_FULL       = 4;
  localparam int ST_FRAME_OPEN = 5;

  function automatic logic [7:0] status_pack(
    input logic busy,
    input logic frame_err,
    input logic overflow,
    input logic empty,
    input logic full,
    input logic frame_open
  );
    logic [7:0] s;
    s                = '0;
    s[ST_BUSY]       = busy;
    s[ST_FRAME_ERR]  = frame_err;
    s[ST_OVERFLOW]   = overflow;
    s[ST_EMPTY]      = empty;
    s[ST_FULL]       = full;
    s[ST_FRAME_OPEN] = frame_open;
    return s;
  endfunction

endpackage

// File: rtl/m_rx_fifo.sv
// Byte FIFO, show-ahead: a write is visible at rd_data/count one cycle later.
// Writes when full and reads when empty are ignored; the caller flags overflow.
module m_rx_fifo #(
  parameter int DEPTH = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [7:0]                wr_data,
  input  logic                      rd_en,
  output logic [7:0]                rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/m_receiver.sv
// 8N1 serial receiver with byte FIFO and idle-gap frame delimiting; byte visible the cycle after its stop-bit sample.
// No backpressure on the line: a byte arriving with the FIFO full is dropped and flagged as overflow.
module m_receiver
  import m_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 12,
  parameter int FIFO_DEPTH   = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  input  logic        i_data_re,
  input  logic        i_frame_ack,
  input  logic        i_clear,
  output logic [7:0]  o_data,
  output logic [15:0] o_data_size,
  output logic [7:0]  o_frames_count,
  output logic [7:0]  o_status
);

  localparam int CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam int FCW        = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_CYCLES);

  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_ok;
  logic             byte_bad;
  logic             start_entry;

  logic [GAP_W-1:0] gap_q;
  logic             open_q;
  logic             gap_close;
  logic [7:0]       frames_q;
  logic             ferr_q;
  logic             ovf_q;

  logic             fifo_push;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Synchronizer and edge-history flops reset high so reset release never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_ok     = 1'b0;
    byte_bad    = 1'b0;
    start_entry = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_sync) begin
          state_d     = START;
          start_entry = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          state_d  = IDLE;
          byte_ok  = rx_sync;
          byte_bad = !rx_sync;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_push = byte_ok && !i_rst;
  assign gap_close = (state_q == IDLE) && open_q && (gap_q == GAP_END);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gap_q    <= '0;
      open_q   <= 1'b0;
      frames_q <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (byte_ok || start_entry || gap_close) begin
        gap_q <= '0;
      end else if (state_q == IDLE && open_q) begin
        gap_q <= gap_q + GAP_W'(1);
      end

      if (byte_ok) begin
        open_q <= 1'b1;
      end else if (gap_close) begin
        open_q <= 1'b0;
      end

      // A close and an ack in the same cycle cancel out.
      if (gap_close && !i_frame_ack) begin
        if (frames_q != 8'hFF) frames_q <= frames_q + 8'd1;
      end else if (i_frame_ack && !gap_close) begin
        if (frames_q != 8'h00) frames_q <= frames_q - 8'd1;
      end

      ferr_q <= byte_bad | (ferr_q & ~i_clear);
      ovf_q  <= (byte_ok & fifo_full) | (ovf_q & ~i_clear);
    end
  end

  m_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (fifo_push),
    .wr_data (shift_q),
    .rd_en   (i_data_re),
    .rd_data (o_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_data_size    = 16'(fifo_count);
  assign o_frames_count = frames_q;
  assign o_status       = status_pack(state_q != IDLE, ferr_q, ovf_q,
                                      fifo_empty, fifo_full, open_q);

endmodule

// File: tb/tb_m_receiver.sv
// Bench for m_receiver: table-driven byte sequence, hand-timed corner cases, and a
// randomized run checked against a queue-based model of the receiver's externally visible rules.
module tb_m_receiver;

  localparam int CPB   = 4;
  localparam int GAP   = 12;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        data_re;
  logic        frame_ack;
  logic        clr;
  logic [7:0]  data;
  logic [15:0] size;
  logic [7:0]  frames;
  logic [7:0]  status;

  int total = 0;
  int bad   = 0;
  logic busy_mid;

  always #5 clk = ~clk;

  m_receiver #(
    .CLKS_PER_BIT (CPB),
    .GAP_BITS     (GAP),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rx           (rx),
    .i_data_re      (data_re),
    .i_frame_ack    (frame_ack),
    .i_clear        (clr),
    .o_data         (data),
    .o_data_size    (size),
    .o_frames_count (frames),
    .o_status       (status)
  );

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         exp_size;
    int         exp_head;
    int         exp_ferr;
    int         exp_ovf;
    int         exp_full;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // rst_bit >= 0 asserts reset during that data bit and holds it until the line is idle again.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int rst_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == rst_bit) rst = 1'b1;
      idle(CPB);
      if (i == 4) busy_mid = status[0];
    end
    rx = stop;
    idle(CPB);
    rx = 1'b1;
    if (rst_bit >= 0) begin
      idle(CPB);
      rst = 1'b0;
      idle(2);
    end
  endtask

  task automatic pop_check(input string name, input int exp);
    check(name, data, exp);
    data_re = 1'b1;
    idle(1);
    data_re = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    idle(1);
    frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    logic [7:0] q[$];
    logic       m_ferr, m_ovf, m_open;
    int         m_frames;
    int         k, n;

    rx = 1'b1; rst = 1'b1; data_re = 1'b0; frame_ack = 1'b0; clr = 1'b0; busy_mid = 1'b0;
    idle(3);
    check("rst_data", data, 0);
    check("rst_size", size, 0);
    check("rst_frames", frames, 0);
    check("rst_status", status, 8'h08);
    rst = 1'b0;
    idle(2);
    check("post_rst_status", status, 8'h08);

    // Table: bytes in order from an empty 4-deep FIFO.
    tbl[0] = '{8'h01, 1'b1, 1, 8'h01, 0, 0, 0};
    tbl[1] = '{8'h00, 1'b1, 2, 8'h01, 0, 0, 0};
    tbl[2] = '{8'hF4, 1'b1, 3, 8'h01, 0, 0, 0};
    tbl[3] = '{8'h55, 1'b0, 3, 8'h01, 1, 0, 0};
    tbl[4] = '{8'h10, 1'b1, 4, 8'h01, 1, 0, 1};
    tbl[5] = '{8'h11, 1'b1, 4, 8'h01, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      send_byte(tbl[i].b, tbl[i].stop, -1);
      idle(2 * CPB);
      check($sformatf("tbl%0d_size", i), size, tbl[i].exp_size);
      check($sformatf("tbl%0d_head", i), data, tbl[i].exp_head);
      check($sformatf("tbl%0d_ferr", i), status[1], tbl[i].exp_ferr);
      check($sformatf("tbl%0d_ovf", i), status[2], tbl[i].exp_ovf);
      check($sformatf("tbl%0d_full", i), status[4], tbl[i].exp_full);
    end
    check("busy_mid_byte", busy_mid, 1);
    check("busy_idle", status[0], 0);
    pop_check("tbl_pop0", 8'h01);
    pop_check("tbl_pop1", 8'h00);
    pop_check("tbl_pop2", 8'hF4);
    pop_check("tbl_pop3", 8'h10);
    check("tbl_empty", status[3], 1);
    check("tbl_empty_data", data, 0);
    check("tbl_sticky", status[2:1], 3);
    pulse_clear();
    check("tbl_cleared", status[2:1], 0);
    pop_check("empty_pop_data", 0);
    check("empty_pop_size", size, 0);

    // Three-byte frame closed by idle gap.
    do_reset();
    send_byte(8'h01, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'hF4, 1'b1, -1);
    idle(2);
    check("frame_open", status[5], 1);
    check("frame_not_closed", frames, 0);
    idle((GAP + 2) * CPB);
    check("frame_size", size, 3);
    check("frame_count", frames, 1);
    check("frame_closed", status[5], 0);
    pop_check("frame_pop0", 8'h01);
    pop_check("frame_pop1", 8'h00);
    pop_check("frame_pop2", 8'hF4);
    check("frame_empty", status[3], 1);

    // One-cycle glitch must not start a byte.
    do_reset();
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(4 * CPB);
    check("glitch_status", status, 8'h08);
    check("glitch_size", size, 0);

    // Bad stop bit.
    send_byte(8'h55, 1'b0, -1);
    idle(2 * CPB);
    check("badstop_ferr", status[1], 1);
    check("badstop_size", size, 0);
    pulse_clear();
    check("badstop_clear", status[1], 0);

    // Overflow on a 4-deep FIFO.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1, -1);
      idle(2 * CPB);
    end
    check("ovf_size", size, 4);
    check("ovf_full", status[4], 1);
    check("ovf_flag", status[2], 1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_pop%0d", i), 8'h10 + i);
    check("ovf_empty", status[3], 1);

    // Reset during data bits abandons the byte.
    do_reset();
    send_byte(8'hA5, 1'b1, 3);
    idle(2 * CPB);
    check("rstmid_size", size, 0);
    check("rstmid_status", status, 8'h08);
    send_byte(8'h3C, 1'b1, -1);
    idle(2 * CPB);
    check("rstmid_size2", size, 1);
    check("rstmid_head", data, 8'h3C);
    check("rstmid_ferr", status[1], 0);

    // Pop in the same cycle as a push keeps the size.
    do_reset();
    send_byte(8'hAA, 1'b1, -1);
    idle(2 * CPB);
    send_byte(8'hBB, 1'b1, -1);
    k = 0;
    for (int i = 1; i <= 4 * CPB; i++) begin
      idle(1);
      if (size == 16'd2) begin k = i; break; end
    end
    check("push_seen", (k > 0) ? 1 : 0, 1);
    if (k == 0) k = 1;
    idle(2 * CPB);
    send_byte(8'hCC, 1'b1, -1);
    repeat (k - 1) idle(1);
    data_re = 1'b1;
    idle(1);
    data_re = 1'b0;
    check("pushpop_size", size, 2);
    check("pushpop_head", data, 8'hBB);
    idle(2 * CPB);
    pop_check("pushpop_pop0", 8'hBB);
    pop_check("pushpop_pop1", 8'hCC);

    // Frame close coinciding with an ack.
    do_reset();
    send_byte(8'h01, 1'b1, -1);
    n = 0;
    for (int i = 1; i <= (GAP + 4) * CPB; i++) begin
      idle(1);
      if (status[5] == 1'b0) begin n = i; break; end
    end
    check("close_seen", (n > 0) ? 1 : 0, 1);
    if (n == 0) n = 1;
    check("ack_cnt1", frames, 1);
    send_byte(8'h02, 1'b1, -1);
    idle((GAP + 4) * CPB);
    check("ack_cnt2", frames, 2);
    send_byte(8'h03, 1'b1, -1);
    repeat (n - 1) idle(1);
    frame_ack = 1'b1;
    idle(1);
    frame_ack = 1'b0;
    check("ack_same_cycle", frames, 2);
    check("ack_same_closed", status[5], 0);
    pulse_ack();
    check("ack_alone", frames, 1);
    pulse_ack();
    pulse_ack();
    check("ack_clamp", frames, 0);

    // Randomized traffic against a queue model.
    do_reset();
    q.delete();
    m_ferr = 1'b0; m_ovf = 1'b0; m_open = 1'b0; m_frames = 0;
    for (int it = 0; it < 40; it++) begin
      logic [7:0] b;
      logic       stop;
      int         np;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      send_byte(b, stop, -1);
      idle(2 * CPB);
      if (stop) begin
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovf = 1'b1;
        m_open = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
      check("rnd_size", size, q.size());
      check("rnd_head", data, (q.size() > 0) ? q[0] : 0);
      check("rnd_ferr", status[1], m_ferr);
      check("rnd_ovf", status[2], m_ovf);
      check("rnd_empty", status[3], (q.size() == 0) ? 1 : 0);
      check("rnd_full", status[4], (q.size() == DEPTH) ? 1 : 0);
      check("rnd_open", status[5], m_open);
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        pop_check("rnd_pop", (q.size() > 0) ? q[0] : 0);
        if (q.size() > 0) void'(q.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clear();
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        idle((GAP + 2) * CPB);
        if (m_open) begin
          if (m_frames < 255) m_frames++;
          m_open = 1'b0;
        end
        check("rnd_frames", frames, m_frames);
        check("rnd_closed", status[5], m_open);
        if ($urandom_range(0, 1) == 0) begin
          pulse_ack();
          if (m_frames > 0) m_frames--;
          check("rnd_ack", frames, m_frames);
        end
      end
    end
    check("rnd_final_size", size, q.size());
    check("rnd_final_frames", frames, m_frames);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
